ir_window_ctrl: RTL and testbench
=================================

Name: ir_window_ctrl

Overview:
- Instruction-byte window controller in front of decode_stage2.
- Accepts 16-byte fetch lines into a 32-byte shift buffer and presents a byte-aligned 128-bit IR, with byte1 (the oldest byte) at IR[127:120].
- Retires the decoded instruction's length each time decode consumes.
- Handles front-end redirects: flush plus a byte offset into the first target line.

Parameters:
- BUF_BYTES, 32, buffer depth in bytes; legal value 32 only (two fetch lines).
- CNT_W, 6, width of the byte-count register (holds 0..32).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- fetch_valid  input  1  fetch line available
- fetch_line  input  128  line bytes; lowest address at [127:120]
- fetch_ready  output  1  controller accepts the line this cycle
- flush  input  1  redirect; discard all buffered bytes
- flush_off  input  4  byte offset of the redirect target within the next accepted line
- ir_valid  output  1  IR holds at least 16 valid bytes
- IR  output  128  aligned instruction window = buf[255:128]
- dec_ready  input  1  decode consumes this cycle
- instr_len  input  4  length of the consumed instruction, 1..15
- len_err  output  1  one-cycle pulse: consume attempted with instr_len==0
- byte_cnt  output  6  current valid-byte count

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - buf=0, byte_cnt=0, state=ALIGN, pend_off=0.
  - ir_valid=0, len_err=0, fetch_ready=1.
- States:
  - ALIGN: waiting for the first line after reset or flush.
  - RUN: normal streaming.
- Combinational outputs, all from registers only (no combinational path from fetch_valid or dec_ready to any output):
  - ir_valid = (byte_cnt >= 16).
  - fetch_ready = !flush && (byte_cnt <= 16).
  - IR = buf[255:128].
- Consume: cons = ir_valid && dec_ready && instr_len != 0.
  - When cons, buf shifts left by instr_len*8 bits and byte_cnt -= instr_len.
  - Vacated low bytes are 0.
- Illegal length: ir_valid && dec_ready && instr_len==0 → no consume, len_err=1 the next cycle, buffer unchanged.
- Fill in RUN: fill = fetch_valid && fetch_ready.
  - The line is written at byte position p = byte_cnt - (cons ? instr_len : 0), i.e. bits [255-8p -: 128].
  - byte_cnt += 16.
- Simultaneous consume + fill: shift and append in the same cycle.
  - Result count = byte_cnt - instr_len + 16, always ≤ 31 since byte_cnt ≤ 16 when fetch_ready.
- Fill in ALIGN (no consume is possible, byte_cnt=0):
  - The line is shifted left by pend_off bytes into buf[255:128].
  - byte_cnt = 16 - pend_off.
  - State → RUN.
- Flush has highest priority. In the flush cycle:
  - byte_cnt=0, buf=0, state=ALIGN, pend_off=flush_off.
  - Any concurrent consume or fetch line is dropped (fetch_ready=0 that cycle).
  - Flush during ALIGN overwrites pend_off.
- Latency: a line accepted in cycle N is visible on IR and byte_cnt in N+1. Consume affects IR in the next cycle.
- byte_cnt never exceeds 32 and never underflows. instr_len ≤ 15 < 16 ≤ byte_cnt whenever cons.
- Reset mid-operation has the same effect as flush with offset 0, plus len_err cleared.

Optional Feature:
- Macro: IR_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32-bit): counts cycles with state==RUN && !ir_valid.
  - Cleared on reset, not on flush, saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then two lines, no redirect:
  - Stimulus: after reset, fetch lines L0=00..0F and L1=10..1F in consecutive cycles.
  - Response: byte_cnt=16 then 32; ir_valid=1 one cycle after L0; IR[127:120]=0x00.
- Consume without refill:
  - Stimulus: with 32 bytes, consume instr_len=3, no fetch.
  - Response: next cycle IR[127:120]=0x03, byte_cnt=29, fetch_ready=0.
- Simultaneous consume + fill:
  - Stimulus: byte_cnt=16 (bytes 10..1F), dec_ready with instr_len=5, same cycle as fetch line 20..2F.
  - Response: byte_cnt=27, IR[127:120]=0x15, byte at position 11 = 0x20.
- Redirect with offset:
  - Stimulus: flush with flush_off=6, then lines 40..4F and 50..5F.
  - Response: after first line byte_cnt=10, ir_valid=0; after second byte_cnt=26, IR[127:120]=0x46.
- Flush beats fetch:
  - Stimulus: flush and fetch_valid in the same cycle.
  - Response: fetch_ready=0, line dropped, byte_cnt=0 next cycle, state=ALIGN.
- Illegal length and stall counter:
  - Stimulus: instr_len=0 with dec_ready and ir_valid.
  - Response: len_err=1 for exactly one cycle, byte_cnt unchanged.
  - With IR_STALL_CNT_EN: RUN with byte_cnt=10 for 4 cycles → stall_cnt increments by 4.

Source files
------------

// File: rtl/ir_window_ctrl.sv
// Instruction-byte window: 32-byte shift buffer feeding a byte-aligned 128-bit IR to decode.
// Optional macro IR_STALL_CNT_EN adds a saturating 32-bit count of starved RUN cycles.
module ir_window_ctrl #(
  parameter int BUF_BYTES = 32,
  parameter int CNT_W     = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_valid,
  input  logic [127:0]       fetch_line,
  output logic               fetch_ready,
  input  logic               flush,
  input  logic [3:0]         flush_off,
  output logic               ir_valid,
  output logic [127:0]       IR,
  input  logic               dec_ready,
  input  logic [3:0]         instr_len,
  output logic               len_err,
  output logic [CNT_W-1:0]   byte_cnt
`ifdef IR_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int BUF_W = BUF_BYTES * 8;
  localparam logic [CNT_W-1:0] LINE_BYTES = CNT_W'(16);

  typedef enum logic {ALIGN, RUN} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         pend_off_q, pend_off_d;
  logic               len_err_q, len_err_d;

  logic               cons;
  logic               fill;
  logic [BUF_W-1:0]   shifted;
  logic [BUF_W-1:0]   line_ext;
  logic [CNT_W-1:0]   wr_pos;

  assign ir_valid    = (cnt_q >= LINE_BYTES);
  assign fetch_ready = !flush && (cnt_q <= LINE_BYTES);
  assign IR          = buf_q[BUF_W-1 -: 128];
  assign byte_cnt    = cnt_q;
  assign len_err     = len_err_q;

  // Bytes past the valid count are kept zero, so appending a line is a plain OR.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    pend_off_d = pend_off_q;
    len_err_d  = ir_valid && dec_ready && (instr_len == 4'd0);
    cons       = ir_valid && dec_ready && (instr_len != 4'd0);
    fill       = fetch_valid && fetch_ready;
    shifted    = cons ? (buf_q << {instr_len, 3'b000}) : buf_q;
    wr_pos     = cnt_q - (cons ? {{(CNT_W-4){1'b0}}, instr_len} : '0);
    line_ext   = {fetch_line, {(BUF_W-128){1'b0}}};

    if (flush) begin
      state_d    = ALIGN;
      buf_d      = '0;
      cnt_d      = '0;
      pend_off_d = flush_off;
    end else if (state_q == ALIGN) begin
      if (fill) begin
        buf_d   = {fetch_line << {pend_off_q, 3'b000}, {(BUF_W-128){1'b0}}};
        cnt_d   = LINE_BYTES - {{(CNT_W-4){1'b0}}, pend_off_q};
        state_d = RUN;
      end
    end else begin
      buf_d = shifted;
      cnt_d = wr_pos;
      if (fill) begin
        buf_d = shifted | (line_ext >> {wr_pos, 3'b000});
        cnt_d = wr_pos + LINE_BYTES;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ALIGN;
      buf_q      <= '0;
      cnt_q      <= '0;
      pend_off_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      pend_off_q <= pend_off_d;
      len_err_q  <= len_err_d;
    end
  end

`ifdef IR_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Survives flush on purpose: it measures starvation across redirects.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == RUN) && !ir_valid && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ir_window_ctrl.sv
// Bench for ir_window_ctrl: directed scenarios then random traffic against a byte-queue model.
module tb_ir_window_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_valid;
  logic [127:0] fetch_line;
  logic         fetch_ready;
  logic         flush;
  logic [3:0]   flush_off;
  logic         ir_valid;
  logic [127:0] ir;
  logic         dec_ready;
  logic [3:0]   instr_len;
  logic         len_err;
  logic [5:0]   byte_cnt;
`ifdef IR_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  ir_window_ctrl dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_line(fetch_line), .fetch_ready(fetch_ready),
    .flush(flush), .flush_off(flush_off),
    .ir_valid(ir_valid), .IR(ir),
    .dec_ready(dec_ready), .instr_len(instr_len),
    .len_err(len_err), .byte_cnt(byte_cnt)
`ifdef IR_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the window is simply an ordered queue of bytes.
  logic [7:0]  m_q[$];
  bit          m_align;
  logic [3:0]  m_pend;
  bit          m_len_err;
  logic [31:0] m_stall;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_ir();
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++)
      if (i < m_q.size()) r[127-8*i -: 8] = m_q[i];
    return r;
  endfunction

  function automatic logic [127:0] mk_line(input logic [7:0] first);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = first + 8'(i);
    return r;
  endfunction

  task automatic check_outputs();
    chk("byte_cnt", 128'(byte_cnt), 128'(m_q.size()));
    chk("ir_valid", 128'(ir_valid), 128'(m_q.size() >= 16));
    chk("fetch_ready", 128'(fetch_ready), 128'(!flush && m_q.size() <= 16));
    chk("IR", ir, model_ir());
    chk("len_err", 128'(len_err), 128'(m_len_err));
`ifdef IR_STALL_CNT_EN
    chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
`endif
  endtask

  task automatic model_update(input bit fv, input logic [127:0] ln, input bit fl,
                              input logic [3:0] off, input bit dr, input logic [3:0] len);
    bit iv = (m_q.size() >= 16);
    bit fr = !fl && (m_q.size() <= 16);
    if (!m_align && !iv && m_stall != 32'hFFFF_FFFF) m_stall++;
    m_len_err = iv && dr && (len == 0);
    if (fl) begin
      m_q.delete();
      m_align = 1;
      m_pend  = off;
    end else begin
      if (iv && dr && len != 0) repeat (len) void'(m_q.pop_front());
      if (fv && fr) begin
        for (int i = (m_align ? int'(m_pend) : 0); i < 16; i++) m_q.push_back(ln[127-8*i -: 8]);
        m_align = 0;
      end
    end
  endtask

  task automatic step(input bit fv, input logic [127:0] ln, input bit fl,
                      input logic [3:0] off, input bit dr, input logic [3:0] len);
    fetch_valid = fv; fetch_line = ln; flush = fl; flush_off = off;
    dec_ready = dr; instr_len = len;
    #1;
    check_outputs();
    @(posedge clk);
    model_update(fv, ln, fl, off, dr, len);
    #1;
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1; fetch_valid = 0; fetch_line = '0; flush = 0; flush_off = 0;
    dec_ready = 0; instr_len = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_q.delete(); m_align = 1; m_pend = 0; m_len_err = 0; m_stall = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st0;
    st0 = 0;
    do_reset();
    chk("reset_cnt", 128'(byte_cnt), 128'(0));
    chk("reset_fr", 128'(fetch_ready), 128'(1));

    // Two lines, no redirect
    step(1, mk_line(8'h00), 0, 0, 0, 0);
    chk("L0_cnt", 128'(byte_cnt), 128'(16));
    chk("L0_iv", 128'(ir_valid), 128'(1));
    step(1, mk_line(8'h10), 0, 0, 0, 0);
    chk("L1_cnt", 128'(byte_cnt), 128'(32));
    chk("L1_top", 128'(ir[127:120]), 128'(8'h00));

    // Consume without refill
    step(0, '0, 0, 0, 1, 3);
    chk("c3_top", 128'(ir[127:120]), 128'(8'h03));
    chk("c3_cnt", 128'(byte_cnt), 128'(29));
    chk("c3_fr", 128'(fetch_ready), 128'(0));

    // Down to 16 bytes (10..1F), then consume + fill together
    step(0, '0, 0, 0, 1, 13);
    chk("c13_top", 128'(ir[127:120]), 128'(8'h10));
    step(1, mk_line(8'h20), 0, 0, 1, 5);
    chk("cf_cnt", 128'(byte_cnt), 128'(27));
    chk("cf_top", 128'(ir[127:120]), 128'(8'h15));
    chk("cf_b11", 128'(ir[39:32]), 128'(8'h20));

    // Redirect with offset 6, stall window while only 10 bytes held
    step(0, '0, 1, 6, 0, 0);
    step(1, mk_line(8'h40), 0, 0, 0, 0);
    chk("rd1_cnt", 128'(byte_cnt), 128'(10));
    chk("rd1_iv", 128'(ir_valid), 128'(0));
`ifdef IR_STALL_CNT_EN
    st0 = stall_cnt;
`endif
    repeat (4) idle();
`ifdef IR_STALL_CNT_EN
    chk("stall4", 128'(stall_cnt - st0), 128'(4));
`endif
    step(1, mk_line(8'h50), 0, 0, 0, 0);
    chk("rd2_cnt", 128'(byte_cnt), 128'(26));
    chk("rd2_top", 128'(ir[127:120]), 128'(8'h46));

    // Flush beats fetch
    fetch_valid = 1; flush = 1; #1;
    chk("ff_fr", 128'(fetch_ready), 128'(0));
    step(1, mk_line(8'h60), 1, 0, 0, 0);
    chk("ff_cnt", 128'(byte_cnt), 128'(0));
    step(1, mk_line(8'h70), 0, 0, 0, 0);
    chk("ff_align", 128'(ir[127:120]), 128'(8'h70));

    // Illegal length
    step(1, mk_line(8'h80), 0, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0);
    chk("le_pulse", 128'(len_err), 128'(1));
    chk("le_cnt", 128'(byte_cnt), 128'(32));
    idle();
    chk("le_clear", 128'(len_err), 128'(0));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bit fv, fl, dr;
      logic [3:0] off, len;
      logic [127:0] ln;
      fv  = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 19) == 0);
      dr  = ($urandom_range(0, 9) < 6);
      off = 4'($urandom_range(0, 15));
      len = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      ln  = {$urandom, $urandom, $urandom, $urandom};
      step(fv, ln, fl, off, dr, len);
    end

    // Reset mid-operation
    do_reset();
    chk("rst2_cnt", 128'(byte_cnt), 128'(0));
    chk("rst2_le", 128'(len_err), 128'(0));
    step(1, mk_line(8'hA0), 0, 0, 0, 0);
    chk("rst2_top", 128'(ir[127:120]), 128'(8'hA0));
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
